// File: rtl/kv_cache_server.sv
// kv_cache_server: stores one packed K row and one packed V row per token and
// streams them back in token order through a backpressure-tolerant port.
// Read path: synchronous array read (p0), then output register, then one skid entry.
module kv_cache_server #(
  parameter int MAX_SEQ_LEN = 2048,
  parameter int HEADS       = 12,
  parameter int DW          = 4,
  parameter int AW          = $clog2(MAX_SEQ_LEN)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [HEADS*DW-1:0] wr_k,
  input  logic [HEADS*DW-1:0] wr_v,
  input  logic                rd_start,
  output logic                rd_busy,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [AW-1:0]       rd_idx,
  output logic [HEADS*DW-1:0] rd_k,
  output logic [HEADS*DW-1:0] rd_v,
  output logic                rd_last,
  output logic                rd_done,
  output logic [AW:0]         seq_len,
  output logic                full,
  output logic                ovf_err
);

  localparam int RW = HEADS * DW;
  localparam logic [AW:0] MAX_LEN = (AW+1)'(MAX_SEQ_LEN);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t state, state_nxt;

  // Write side and stream bookkeeping
  logic          wr_fire;
  logic          clr_eff;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   seq_len_nxt;
  logic [AW:0]   len;
  logic [AW:0]   ptr;
  logic          issue;
  logic [AW:0]   issue_idx;
  logic [AW:0]   issue_len;
  logic [1:0]    occ;
  logic          pop;

  // Storage
  logic [RW-1:0] k_mem [MAX_SEQ_LEN];
  logic [RW-1:0] v_mem [MAX_SEQ_LEN];

  // Read stage
  logic          vld_p0;
  logic [AW-1:0] idx_p0;
  logic          last_p0;
  logic [RW-1:0] mem_k_p0, mem_v_p0;
  logic          fwd_p0;
  logic [RW-1:0] fwd_k_p0, fwd_v_p0;
  logic [RW-1:0] k_p0, v_p0;

  // Output register and skid entry
  logic          last_q;
  logic          skid_vld;
  logic [AW-1:0] skid_idx;
  logic          skid_last;
  logic [RW-1:0] skid_k, skid_v;
  logic          out_take;
  logic          out_load;
  logic          skid_load;

  assign full    = (seq_len == MAX_LEN);
  assign pop     = rd_valid && rd_ready;
  assign rd_last = rd_valid && last_q;
  assign k_p0    = fwd_p0 ? fwd_k_p0 : mem_k_p0;
  assign v_p0    = fwd_p0 ? fwd_v_p0 : mem_v_p0;

  // Entries held downstream once this cycle's beat (if any) leaves
  assign occ = 2'(rd_valid) + 2'(skid_vld) + 2'(vld_p0) - 2'(pop);

  // Output register can accept a new entry when empty or when its beat is consumed
  assign out_take  = pop || !rd_valid;
  assign out_load  = out_take && (skid_vld || vld_p0);
  assign skid_load = vld_p0 && (!out_take || skid_vld);

  // Next-state, write acceptance, read issue and status outputs
  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    issue_idx   = ptr;
    issue_len   = len;
    rd_busy     = 1'b0;
    rd_done     = 1'b0;
    wr_ready    = (state == IDLE) && !full;
    wr_fire     = wr_valid && wr_ready;
    clr_eff     = clr && (state == IDLE);
    wr_addr     = clr_eff ? '0 : seq_len[AW-1:0];
    seq_len_nxt = clr_eff ? '0 : seq_len;
    if (wr_fire) seq_len_nxt = {1'b0, wr_addr} + ONE;
    case (state)
      IDLE: begin
        if (rd_start) begin
          issue_len = seq_len_nxt;
          if (seq_len_nxt == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = STREAM;
            issue     = 1'b1;
            issue_idx = '0;
          end
        end
      end
      STREAM: begin
        rd_busy = 1'b1;
        if ((ptr < len) && (occ <= 2'd1)) issue = 1'b1;
        if (pop && rd_last) state_nxt = DONE;
      end
      DONE: begin
        rd_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers: state, token count, overflow flag, stream snapshot and pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      seq_len <= '0;
      ovf_err <= 1'b0;
      len     <= '0;
      ptr     <= '0;
    end else begin
      state   <= state_nxt;
      seq_len <= seq_len_nxt;
      if (wr_valid && full) ovf_err <= 1'b1;
      if ((state == IDLE) && rd_start) len <= seq_len_nxt;
      if (issue) ptr <= issue_idx + ONE;
    end
  end

  // Row storage with registered read; a same-cycle write to the read address is forwarded
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      k_mem[wr_addr] <= wr_k;
      v_mem[wr_addr] <= wr_v;
    end
    if (issue) begin
      mem_k_p0 <= k_mem[issue_idx[AW-1:0]];
      mem_v_p0 <= v_mem[issue_idx[AW-1:0]];
      fwd_p0   <= wr_fire && (wr_addr == issue_idx[AW-1:0]);
      fwd_k_p0 <= wr_k;
      fwd_v_p0 <= wr_v;
      idx_p0   <= issue_idx[AW-1:0];
      last_p0  <= ((issue_idx + ONE) == issue_len);
    end
  end

  // ---- read stage (p0) -> output register / skid boundary ----
  // Read-stage valid tracks issued reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= issue;
  end

  // Output register: load from skid first, else straight from the read stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_idx   <= '0;
      rd_k     <= '0;
      rd_v     <= '0;
      last_q   <= 1'b0;
      skid_vld <= 1'b0;
    end else begin
      if (out_take) begin
        rd_valid <= skid_vld || vld_p0;
        skid_vld <= skid_vld && vld_p0;
      end else begin
        skid_vld <= skid_vld || vld_p0;
      end
      if (out_load) begin
        rd_idx <= skid_vld ? skid_idx  : idx_p0;
        rd_k   <= skid_vld ? skid_k    : k_p0;
        rd_v   <= skid_vld ? skid_v    : v_p0;
        last_q <= skid_vld ? skid_last : last_p0;
      end
    end
  end

  // Skid entry payload catches a read that lands while the output is stalled
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_idx  <= idx_p0;
      skid_last <= last_p0;
      skid_k    <= k_p0;
      skid_v    <= v_p0;
    end
  end

endmodule

// File: tb/tb_kv_cache_server.sv
// Directed testbench for kv_cache_server with an 8-token capacity.
module tb_kv_cache_server;

  localparam int MAX = 8;
  localparam int AW  = 3;
  localparam int RW  = 48;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [RW-1:0] wr_k = '0;
  logic [RW-1:0] wr_v = '0;
  logic          rd_start = 1'b0;
  logic          rd_busy;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [AW-1:0] rd_idx;
  logic [RW-1:0] rd_k;
  logic [RW-1:0] rd_v;
  logic          rd_last;
  logic          rd_done;
  logic [AW:0]   seq_len;
  logic          full;
  logic          ovf_err;

  int n_checks = 0;
  int n_pass   = 0;

  kv_cache_server #(.MAX_SEQ_LEN(MAX), .HEADS(12), .DW(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_k(wr_k), .wr_v(wr_v),
    .rd_start(rd_start), .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_idx(rd_idx), .rd_k(rd_k), .rd_v(rd_v), .rd_last(rd_last), .rd_done(rd_done),
    .seq_len(seq_len), .full(full), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] row(input int n);
    logic [3:0] d;
    d = 4'(n);
    return {12{d}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clr = 1'b0; wr_valid = 1'b0; rd_start = 1'b0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic write_row(input logic [RW-1:0] k);
    wr_valid = 1'b1; wr_k = k; wr_v = ~k;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (seq_len !== 4'd0) $display("FAIL reset_seq_len got %0d want 0", seq_len); else n_pass++;
    n_checks++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %0b want 1", wr_ready); else n_pass++;
    n_checks++; if ({rd_valid, rd_busy, rd_done, rd_last, ovf_err, full} !== 6'b0)
      $display("FAIL reset_flags got %06b want 000000", {rd_valid, rd_busy, rd_done, rd_last, ovf_err, full}); else n_pass++;
    n_checks++; if ({rd_idx, rd_k, rd_v} !== '0) $display("FAIL reset_data got %h want 0", {rd_idx, rd_k, rd_v}); else n_pass++;
  endtask

  task automatic test_basic_stream();
    do_reset();
    for (int i = 1; i <= 3; i++) write_row(row(i));
    rd_ready = 1'b1; rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    n_checks++; if (rd_valid !== 1'b0 || rd_busy !== 1'b1)
      $display("FAIL basic_t1 got valid=%0b busy=%0b want 0/1", rd_valid, rd_busy); else n_pass++;
    step();
    for (int b = 0; b < 3; b++) begin
      n_checks++; if (rd_valid !== 1'b1 || rd_idx !== 3'(b) || rd_last !== (b == 2))
        $display("FAIL basic_beat%0d got valid=%0b idx=%0d last=%0b want 1/%0d/%0b", b, rd_valid, rd_idx, rd_last, b, b == 2); else n_pass++;
      n_checks++; if (rd_k !== row(b + 1) || rd_v !== ~row(b + 1))
        $display("FAIL basic_data%0d got k=%h v=%h want k=%h", b, rd_k, rd_v, row(b + 1)); else n_pass++;
      n_checks++; if (seq_len !== 4'd3) $display("FAIL basic_seq_len%0d got %0d want 3", b, seq_len); else n_pass++;
      step();
    end
    n_checks++; if (rd_done !== 1'b1 || rd_valid !== 1'b0 || rd_busy !== 1'b0)
      $display("FAIL basic_done got done=%0b valid=%0b busy=%0b want 1/0/0", rd_done, rd_valid, rd_busy); else n_pass++;
    step();
    n_checks++; if (rd_done !== 1'b0) $display("FAIL basic_done_pulse got %0b want 0", rd_done); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [5:0] pat;
    int hs;
    int cyc;
    pat = 6'b101001;  // bit c is rd_ready in cycle c: 1,0,0,1,0,1
    hs = 0; cyc = 0;
    do_reset();
    for (int i = 1; i <= 3; i++) write_row(row(i));
    rd_ready = 1'b0; rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    step();
    while (hs < 3 && cyc < 20) begin
      rd_ready = (cyc < 6) ? pat[cyc] : 1'b1;
      n_checks++; if (rd_valid !== 1'b1 || rd_idx !== 3'(hs) || rd_k !== row(hs + 1) || rd_last !== (hs == 2))
        $display("FAIL bp_cycle%0d got valid=%0b idx=%0d k=%h last=%0b want 1/%0d/%h/%0b",
                 cyc, rd_valid, rd_idx, rd_k, rd_last, hs, row(hs + 1), hs == 2); else n_pass++;
      if (rd_valid && rd_ready) hs++;
      step();
      cyc++;
    end
    n_checks++; if (cyc !== 6) $display("FAIL bp_cycles got %0d want 6", cyc); else n_pass++;
    n_checks++; if (rd_done !== 1'b1 || rd_valid !== 1'b0)
      $display("FAIL bp_done got done=%0b valid=%0b want 1/0", rd_done, rd_valid); else n_pass++;
    rd_ready = 1'b0;
  endtask

  task automatic test_full_ovf();
    do_reset();
    for (int i = 1; i <= 8; i++) write_row(row(i));
    n_checks++; if (full !== 1'b1 || wr_ready !== 1'b0 || seq_len !== 4'd8)
      $display("FAIL full_flags got full=%0b wr_ready=%0b len=%0d want 1/0/8", full, wr_ready, seq_len); else n_pass++;
    n_checks++; if (ovf_err !== 1'b0) $display("FAIL full_no_ovf got %0b want 0", ovf_err); else n_pass++;
    write_row(row(9));
    n_checks++; if (ovf_err !== 1'b1 || seq_len !== 4'd8)
      $display("FAIL full_ovf got ovf=%0b len=%0d want 1/8", ovf_err, seq_len); else n_pass++;
    rd_ready = 1'b1; rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    step();
    for (int b = 0; b < 8; b++) begin
      n_checks++; if (rd_valid !== 1'b1 || rd_idx !== 3'(b) || rd_k !== row(b + 1) || rd_v !== ~row(b + 1) || rd_last !== (b == 7))
        $display("FAIL full_beat%0d got valid=%0b idx=%0d k=%h last=%0b want 1/%0d/%h/%0b",
                 b, rd_valid, rd_idx, rd_k, rd_last, b, row(b + 1), b == 7); else n_pass++;
      step();
    end
    n_checks++; if (rd_done !== 1'b1) $display("FAIL full_done got %0b want 1", rd_done); else n_pass++;
  endtask

  task automatic test_empty();
    int seen;
    seen = 0;
    do_reset();
    rd_ready = 1'b1; rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    n_checks++; if (rd_done !== 1'b1 || rd_busy !== 1'b0 || rd_valid !== 1'b0)
      $display("FAIL empty_done got done=%0b busy=%0b valid=%0b want 1/0/0", rd_done, rd_busy, rd_valid); else n_pass++;
    for (int c = 0; c < 4; c++) begin
      step();
      if (rd_valid || rd_busy || rd_done) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL empty_quiet got %0d active cycles want 0", seen); else n_pass++;
  endtask

  task automatic test_clr_write();
    logic [11:0] abc;
    abc = 12'hABC;
    do_reset();
    for (int i = 1; i <= 5; i++) write_row(row(i));
    clr = 1'b1;
    write_row({4{abc}});
    clr = 1'b0;
    n_checks++; if (seq_len !== 4'd1) $display("FAIL clr_seq_len got %0d want 1", seq_len); else n_pass++;
    rd_ready = 1'b1; rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    step();
    n_checks++; if (rd_valid !== 1'b1 || rd_idx !== 3'd0 || rd_k !== {4{abc}} || rd_v !== ~{4{abc}} || rd_last !== 1'b1)
      $display("FAIL clr_beat got valid=%0b idx=%0d k=%h last=%0b want 1/0/%h/1", rd_valid, rd_idx, rd_k, rd_last, {4{abc}}); else n_pass++;
    step();
    n_checks++; if (rd_done !== 1'b1) $display("FAIL clr_done got %0b want 1", rd_done); else n_pass++;
  endtask

  task automatic test_start_with_write();
    do_reset();
    rd_ready = 1'b1; rd_start = 1'b1;
    write_row(row(5));
    rd_start = 1'b0;
    step();
    n_checks++; if (rd_valid !== 1'b1 || rd_idx !== 3'd0 || rd_k !== row(5) || rd_last !== 1'b1)
      $display("FAIL startwr_beat got valid=%0b idx=%0d k=%h last=%0b want 1/0/%h/1", rd_valid, rd_idx, rd_k, rd_last, row(5)); else n_pass++;
    step();
    n_checks++; if (rd_done !== 1'b1) $display("FAIL startwr_done got %0b want 1", rd_done); else n_pass++;
  endtask

  task automatic test_reset_mid_stream();
    int dones;
    dones = 0;
    do_reset();
    for (int i = 1; i <= 5; i++) write_row(row(i));
    rd_ready = 1'b1; rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    step();
    step();
    step();
    n_checks++; if (rd_valid !== 1'b1 || rd_idx !== 3'd2)
      $display("FAIL midrst_pre got valid=%0b idx=%0d want 1/2", rd_valid, rd_idx); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({rd_valid, rd_busy, rd_done, rd_last} !== 4'b0 || seq_len !== 4'd0 || {rd_idx, rd_k, rd_v} !== '0)
      $display("FAIL midrst_async got flags=%04b len=%0d data=%h want 0/0/0", {rd_valid, rd_busy, rd_done, rd_last}, seq_len, {rd_idx, rd_k, rd_v}); else n_pass++;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (rd_done || rd_valid) dones++;
      step();
    end
    n_checks++; if (dones !== 0 || seq_len !== 4'd0)
      $display("FAIL midrst_after got active=%0d len=%0d want 0/0", dones, seq_len); else n_pass++;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    n_checks++; if (rd_done !== 1'b1 || rd_valid !== 1'b0)
      $display("FAIL midrst_restart got done=%0b valid=%0b want 1/0", rd_done, rd_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_full_ovf();
    test_empty();
    test_clr_write();
    test_start_with_write();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/kv_cache_server.md
Name: kv_cache_server

Overview:
- Responder side of the KV-cache interface used by the attention top-level FSM. Stores one packed K row and one packed V row per token.
- Writes are accepted through a valid/ready port.
- On request, streams the stored rows back in token order (index 0 to seq_len-1) through a valid/ready port that tolerates backpressure.
- Sits between the projection unit (writer) and the K/V loaders that feed qk_matmul and attn_reader (reader).

Parameters:
- MAX_SEQ_LEN, 2048: token capacity (power of two).
- HEADS, 12: lanes per row.
- DW, 4: bits per lane.
- AW, $clog2(MAX_SEQ_LEN): derived index width; not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  clear stored token count.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accept.
- wr_k  in  HEADS*DW  K row to store.
- wr_v  in  HEADS*DW  V row to store.
- rd_start  in  1  begin streaming the stored rows.
- rd_busy  out  1  stream in progress.
- rd_valid  out  1  output beat valid.
- rd_ready  in  1  consumer accepts beat.
- rd_idx  out  AW  token index of current beat.
- rd_k  out  HEADS*DW  K row of current beat.
- rd_v  out  HEADS*DW  V row of current beat.
- rd_last  out  1  current beat is index seq_len-1.
- rd_done  out  1  one-cycle pulse when stream ends.
- seq_len  out  AW+1  tokens stored.
- full  out  1  seq_len==MAX_SEQ_LEN.
- ovf_err  out  1  sticky: write attempted while full.

Behaviour:
- Reset (rst_n low, async): state IDLE, seq_len=0, rd_valid/rd_last/rd_done/rd_busy/ovf_err=0, rd_idx=0, rd_k/rd_v=0. Memory contents are not cleared.
- Storage: two synchronous single-port-write, single-port-read arrays (K, V), MAX_SEQ_LEN x HEADS*DW, with 1-cycle read latency.
- wr_ready = (state==IDLE) && !full. Combinational, so it is 1 out of reset.
- Write accepted when wr_valid && wr_ready: row stored at address seq_len, seq_len increments.
- wr_valid while full: row dropped, ovf_err set; ovf_err clears only on reset.
- clr is honoured only in IDLE and sets seq_len=0. clr together with an accepted write: the row goes to address 0 and seq_len becomes 1.
- full = (seq_len==MAX_SEQ_LEN). There is no wrap-around; writes never overwrite while full.
- States:
  - IDLE: rd_start (while IDLE) latches len = seq_len after this cycle's clr/write. This includes a same-cycle accepted write; a same-cycle clr gives len 0 or 1.
    - If len==0: go to DONE.
    - Otherwise: set rd_busy=1, issue read of address 0, go to STREAM.
  - STREAM: prefetch pipeline (read stage plus output register plus one skid entry).
    - First rd_valid appears 2 cycles after the rd_start edge.
    - With rd_ready held high: one beat per cycle, no bubbles.
    - While rd_valid && !rd_ready: rd_idx, rd_k, rd_v and rd_last hold stable. No beat is dropped or duplicated.
    - On the handshake of the beat with rd_last=1, go to DONE.
  - DONE: rd_done=1 for exactly one cycle, rd_busy=0, then IDLE.
- rd_start outside IDLE is ignored. clr outside IDLE is ignored. Writes are blocked outside IDLE (wr_ready=0), so the snapshot stays consistent.
- rd_last=1 only when rd_valid=1 and rd_idx==len-1.
- rd_k/rd_v hold their last value when rd_valid=0. Consumers must not sample them then.
- rst_n asserted mid-stream aborts immediately to the reset values. No rd_done is produced. seq_len=0 afterwards.

Test Plan:
- MAX_SEQ_LEN=8, HEADS=12, DW=4. Write rows with wr_k = 48'h111..., 48'h222..., 48'h333... (wr_v = bitwise inverse). Pulse rd_start at cycle T with rd_ready=1.
  -> Beats idx 0,1,2 at T+2, T+3, T+4 with matching data; rd_last at idx 2; rd_done at T+5; seq_len=3 throughout.
- Same 3 rows, rd_ready pattern 1,0,0,1,0,1.
  -> rd_valid stays high from T+2; data held stable during stalls; exactly 3 handshakes, in order 0,1,2; rd_done one cycle after the third handshake.
- Write 8 rows.
  -> full=1, wr_ready=0. Then a 9th wr_valid gives ovf_err=1 and seq_len stays 8. A following stream returns 8 beats, idx 0..7, with rows 0..7 intact.
- rd_start with seq_len=0.
  -> rd_done=1 at T+1; rd_valid never asserts; rd_busy stays 0.
- With seq_len=5, assert clr together with wr_valid carrying row 0xABC...
  -> seq_len=1. A following stream returns a single beat, idx 0, data 0xABC..., rd_last=1.
- Assert rst_n low for 1 cycle after the second beat of a 5-row stream.
  -> All outputs go to reset values asynchronously; no rd_done; seq_len=0. A subsequent rd_start gives rd_done at T+1 with no beats.
